seq_subtractor: RTL and testbench
=================================

SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

Interface
REQ-001 Parameters: none; the datapath is fixed at 32 bits, processed 4 bits per cycle.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 a  input  32  minuend; sampled on the accepted start edge.
REQ-006 b  input  32  subtrahend; sampled on the accepted start edge.
REQ-007 bin  input  1  borrow-in; sampled on the accepted start edge.
REQ-008 diff  output  32  registered result, a - b - bin mod 2^32.
REQ-009 bout  output  1  registered borrow-out; 1 iff unsigned a < b + bin.
REQ-010 ovf  output  1  registered signed overflow of a - b - bin.
REQ-011 zero  output  1  registered; 1 iff diff == 0.
REQ-012 busy  output  1  1 while in RUN.
REQ-013 done  output  1  one-cycle pulse; result outputs are valid.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE or DONE with start=1 SHALL capture a, b and bin into internal registers.
REQ-016 On that capture edge: carry register = ~bin, nibble counter = 0, next state = RUN.
REQ-017 RUN, each cycle: compute {c, d} = a_r[4k+3:4k] + ~b_r[4k+3:4k] + carry for k = counter.
REQ-018 RUN, each cycle: store d into the partial-result register bits [4k+3:4k], set carry = c, increment counter.
REQ-019 RUN with counter == 7: next state = DONE.
REQ-020 On entering DONE: update diff, bout = ~carry, ovf = carry-into-bit31 XOR carry-out-of-bit31, zero = (diff == 0), all together.
REQ-021 done SHALL be 1 for exactly the one cycle spent in DONE.
REQ-022 DONE with start=0: next state = IDLE. DONE with start=1: back-to-back start per REQ-015/REQ-016.
REQ-023 Latency: start accepted at edge E0 -> busy=1 after E0 through E8 -> done=1 for the cycle after E8.
REQ-024 diff/bout/ovf/zero SHALL hold their last values until the next DONE; RUN never alters them.
REQ-025 start while in RUN SHALL be ignored; operands SHALL NOT change and latency SHALL NOT extend.
REQ-026 Counter SHALL be 3 bits; it wraps 7 -> 0 only on the RUN -> DONE transition.
REQ-027 busy and done SHALL never be 1 simultaneously.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state = IDLE, counter = 0, carry = 0, diff = 0, bout = 0, ovf = 0, zero = 0, busy = 0, done = 0.
REQ-029 Reset asserted during RUN SHALL abort the operation with no done pulse.
REQ-030 After rst_n deasserts, the first start SHALL be accepted on the first clock edge where it is sampled high.

Verification
REQ-031 a=5, b=3, bin=0 -> done after 9 edges; diff=0x00000002, bout=0, ovf=0, zero=0.
REQ-032 a=0, b=1, bin=0 -> diff=0xFFFFFFFF, bout=1, ovf=0, zero=0.
REQ-033 a=0x80000000, b=1, bin=0 -> diff=0x7FFFFFFF, bout=0, ovf=1.
REQ-034 a=0x12345678, b=0x12345677, bin=1 -> diff=0, zero=1, bout=0, ovf=0.
REQ-035 start pulsed at cycle 3 of RUN with new operands -> ignored; original result and a single done pulse.
REQ-036 rst_n low at cycle 4 of RUN -> all outputs 0 immediately, no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/seq_subtractor.sv
// Sequential 32-bit subtractor: computes a - b - bin one nibble per cycle
// using a + ~b + ~bin, then publishes diff/bout/ovf/zero with a one-cycle done pulse.
module seq_subtractor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bin,
    output logic [31:0] diff,
    output logic        bout,
    output logic        ovf,
    output logic        zero,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] part_q, part_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        carry_q, carry_d;
    logic [31:0] diff_q, diff_d;
    logic        bout_q, bout_d;
    logic        ovf_q, ovf_d;
    logic        zero_q, zero_d;

    logic [4:0]  idx;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [4:0]  sum;
    logic [31:0] part_next;

    always_comb begin
        idx       = {cnt_q, 2'b00};
        nib_a     = a_q[idx +: 4];
        nib_b     = b_q[idx +: 4];
        sum       = {1'b0, nib_a} + {1'b0, ~nib_b} + {4'b0000, carry_q};
        part_next = part_q;
        part_next[idx +: 4] = sum[3:0];

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ~bin;
                    cnt_d   = 3'd0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                part_d  = part_next;
                carry_d = sum[4];
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_DONE;
                    diff_d  = part_next;
                    bout_d  = ~sum[4];
                    // Carry into bit 31 recovered from the top sum bit and its operands.
                    ovf_d   = (sum[3] ^ nib_a[3] ^ ~nib_b[3]) ^ sum[4];
                    zero_d  = (part_next == 32'd0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            part_q  <= 32'd0;
            cnt_q   <= 3'd0;
            carry_q <= 1'b0;
            diff_q  <= 32'd0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_subtractor.sv
// Randomized bench for seq_subtractor against a plain-arithmetic reference model.
module tb_seq_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] held_diff;
    logic        held_bout;
    logic        held_ovf;
    logic        held_zero;

    seq_subtractor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_held();
        check_eq("held_diff", 64'(diff), 64'(held_diff));
        check_eq("held_bout", 64'(bout), 64'(held_bout));
        check_eq("held_ovf",  64'(ovf),  64'(held_ovf));
        check_eq("held_zero", 64'(zero), 64'(held_zero));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_diff"}, 64'(diff), 64'd0);
        check_eq({tag, "_bout"}, 64'(bout), 64'd0);
        check_eq({tag, "_ovf"},  64'(ovf),  64'd0);
        check_eq({tag, "_zero"}, 64'(zero), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // mode 0: plain op, 1: stray start mid-run, 2: reset mid-run.
    // Called at a negedge; returns at a negedge.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin,
                          input int mode);
        logic [32:0] wide;
        longint      sr;
        logic [31:0] e_diff;
        logic        e_bout;
        logic        e_ovf;
        logic        e_zero;
        bit          got_done;

        wide   = {1'b0, ta} - {1'b0, tb_v} - {32'd0, tbin};
        e_diff = wide[31:0];
        e_bout = wide[32];
        sr     = longint'($signed(ta)) - longint'($signed(tb_v)) - longint'(tbin);
        e_ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e_zero = (e_diff == 32'd0);

        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        got_done = 0;
        for (int cyc = 1; cyc <= 12 && !got_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (mode == 1 && cyc == 3) begin
                start = 1'b1;
                a     = $urandom;
                b     = $urandom;
                bin   = 1'($urandom_range(0, 1));
            end
            if (mode == 2 && cyc == 4) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("rst_run");
                held_diff = 32'd0; held_bout = 1'b0; held_ovf = 1'b0; held_zero = 1'b0;
                @(negedge clk);
                check_all_zero("rst_hold");
                rst_n = 1'b1;
                return;
            end
            check_eq("busy_done_excl", 64'(busy & done), 64'd0);
            if (done) begin
                got_done = 1;
                check_eq("latency", 64'(cyc), 64'd9);
                check_eq("diff", 64'(diff), 64'(e_diff));
                check_eq("bout", 64'(bout), 64'(e_bout));
                check_eq("ovf",  64'(ovf),  64'(e_ovf));
                check_eq("zero", 64'(zero), 64'(e_zero));
                held_diff = e_diff; held_bout = e_bout; held_ovf = e_ovf; held_zero = e_zero;
            end else begin
                check_eq("busy_run", 64'(busy), 64'd1);
                check_held();
            end
        end
        if (!got_done) check_eq("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("idle_busy", 64'(busy), 64'd0);
            check_eq("idle_done", 64'(done), 64'd0);
            check_held();
        end
    endtask

    initial begin
        logic [31:0] edge_vals [6];
        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'hFFFF_FFFF;
        edge_vals[2] = 32'h8000_0000;
        edge_vals[3] = 32'h7FFF_FFFF;
        edge_vals[4] = 32'h0000_0001;
        edge_vals[5] = 32'h8000_0001;

        rst_n = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0; bin = 1'b0;
        held_diff = 32'd0; held_bout = 1'b0; held_ovf = 1'b0; held_zero = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        run_op(32'd5, 32'd3, 1'b0, 0);
        idle_cycles(1);
        run_op(32'd0, 32'd1, 1'b0, 0);
        run_op(32'h8000_0000, 32'd1, 1'b0, 0);
        run_op(32'h1234_5678, 32'h1234_5677, 1'b1, 0);
        idle_cycles(2);
        run_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1);
        idle_cycles(1);
        run_op(32'hCAFE_F00D, 32'h1111_2222, 1'b1, 2);
        run_op(32'h0000_00FF, 32'h0000_0100, 1'b1, 0);
        idle_cycles(1);

        for (int i = 0; i < 36; i++) begin
            run_op(edge_vals[i % 6], edge_vals[(i / 6) % 6], 1'($urandom_range(0, 1)), 0);
            idle_cycles($urandom_range(0, 2));
        end
        for (int i = 0; i < 40; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 0);
            idle_cycles($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
